// File: rtl/lcd_pkg.sv
// Shared constants, opcode masks and DDRAM address mapping for the LCD responder.
package lcd_pkg;

   // Instruction opcode masks; the highest set bit selects the instruction
   localparam logic [7:0] OP_CLEAR  = 8'h01;
   localparam logic [7:0] OP_HOME   = 8'h02;
   localparam logic [7:0] OP_ENTRY  = 8'h04;
   localparam logic [7:0] OP_DISP   = 8'h08;
   localparam logic [7:0] OP_SHIFT  = 8'h10;
   localparam logic [7:0] OP_FUNC   = 8'h20;
   localparam logic [7:0] OP_CGRAM  = 8'h40;
   localparam logic [7:0] OP_DDRAM  = 8'h80;

   localparam logic [7:0]  SPACE       = 8'h20;
   localparam logic [6:0]  LINE2_BASE  = 7'h40;
   localparam int unsigned LINE_LEN    = 16;
   localparam logic [6:0]  LINE_END    = 7'h27;
   localparam logic [6:0]  LINE2_END   = 7'h67;
   localparam int unsigned DDRAM_DEPTH = 2 * LINE_LEN;

   typedef struct packed {
      logic       hit;
      logic [4:0] idx;
   } ddram_loc_t;

   // AC 0x00-0x0F -> 0-15, 0x40-0x4F -> 16-31; everything else has no storage
   function automatic ddram_loc_t ddram_map(input logic [6:0] ac);
      ddram_loc_t loc;
      loc.hit = (ac[5:4] == 2'b00);
      loc.idx = {ac[6], ac[3:0]};
      return loc;
   endfunction

endpackage

// File: rtl/lcd_ac_step.sv
// Next address-counter value with the two-line wrap rules.
module lcd_ac_step
   import lcd_pkg::*;
(
   input  logic [6:0] ac_i,
   input  logic       inc_i,
   output logic [6:0] ac_next_o
);

   logic in_range;

   // Wrap at line ends; out-of-range addresses snap to the wrap target
   always_comb begin
      ac_next_o = ac_i;
      if (inc_i) begin
         in_range = (ac_i < LINE_END) || ((ac_i >= LINE2_BASE) && (ac_i < LINE2_END));
         if (ac_i == LINE_END)       ac_next_o = LINE2_BASE;
         else if (ac_i == LINE2_END) ac_next_o = 7'h00;
         else if (in_range)          ac_next_o = 7'(ac_i + 7'd1);
         else                        ac_next_o = 7'h00;
      end else begin
         in_range = ((ac_i > 7'h00) && (ac_i <= LINE_END)) ||
                    ((ac_i > LINE2_BASE) && (ac_i <= LINE2_END));
         if (ac_i == LINE2_BASE)     ac_next_o = LINE_END;
         else if (ac_i == 7'h00)     ac_next_o = LINE2_END;
         else if (in_range)          ac_next_o = 7'(ac_i - 7'd1);
         else                        ac_next_o = LINE2_END;
      end
   end

endmodule

// File: rtl/lcd_responder.sv
// HD44780-style bus responder: decodes LCD bus accesses into a 2x16 DDRAM image.
module lcd_responder
   import lcd_pkg::*;
#(
   parameter int unsigned BUSY_CYCLES  = 2000,
   parameter int unsigned CLEAR_CYCLES = 82000
) (
   input  logic       iCLK,
   input  logic       iRST,
   input  logic [7:0] LCD_DATA,
   input  logic       LCD_RW,
   input  logic       LCD_EN,
   input  logic       LCD_RS,
   output logic [7:0] oLCD_DQ,
   output logic       oLCD_DQ_OE,
   input  logic [4:0] iRD_ADDR,
   output logic [7:0] oRD_CHAR,
   output logic [6:0] oAC,
   output logic       oDISP_ON,
   output logic       oBUSY,
   output logic       oDROP
);

   localparam int unsigned CW = $clog2(CLEAR_CYCLES + 1);

   logic [1:0]    en_sync_q, rs_sync_q, rw_sync_q;
   logic [7:0]    data_s1_q, data_s2_q;
   logic          en_d3_q;
   logic          en_s, rs_s, rw_s, strobe_c;

   logic [6:0]    ac_q, ac_d, ac_next_c;
   logic          id_q, id_d, sel_q, sel_d, disp_q, disp_d;
   logic          busy_q, drop_q, drop_d;
   logic [CW-1:0] cnt_q;
   logic          start_c, long_c, wr_c, clr_c, step_inc_c;
   logic [7:0]    dq_q;
   logic          dq_oe_q;
   logic [7:0]    ddram_q [DDRAM_DEPTH];
   logic          fill_q;
   logic [4:0]    fill_idx_q;
   logic [7:0]    rd_char_q, ac_char_c;
   ddram_loc_t    ac_loc_c;

   // Two-flop synchronizer plus one extra EN stage for falling-edge detect
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         en_sync_q <= '0;
         rs_sync_q <= '0;
         rw_sync_q <= '0;
         data_s1_q <= '0;
         data_s2_q <= '0;
         en_d3_q   <= 1'b0;
      end else begin
         en_sync_q <= {en_sync_q[0], LCD_EN};
         rs_sync_q <= {rs_sync_q[0], LCD_RS};
         rw_sync_q <= {rw_sync_q[0], LCD_RW};
         data_s1_q <= LCD_DATA;
         data_s2_q <= data_s1_q;
         en_d3_q   <= en_sync_q[1];
      end
   end

   assign en_s     = en_sync_q[1];
   assign rs_s     = rs_sync_q[1];
   assign rw_s     = rw_sync_q[1];
   assign strobe_c = en_d3_q & ~en_s;

   // Data/read paths step per I/D; the cursor-shift instruction supplies its own direction
   assign step_inc_c = rs_s ? id_q : data_s2_q[2];

   lcd_ac_step u_ac_step (
      .ac_i      (ac_q),
      .inc_i     (step_inc_c),
      .ac_next_o (ac_next_c)
   );

   assign ac_loc_c  = ddram_map(ac_q);
   assign ac_char_c = ac_loc_c.hit ? ddram_q[ac_loc_c.idx] : SPACE;

   // Access decode: reads always act, writes are dropped while busy
   always_comb begin
      ac_d    = ac_q;
      id_d    = id_q;
      sel_d   = sel_q;
      disp_d  = disp_q;
      drop_d  = 1'b0;
      start_c = 1'b0;
      long_c  = 1'b0;
      wr_c    = 1'b0;
      clr_c   = 1'b0;
      if (strobe_c) begin
         if (rw_s) begin
            if (rs_s) ac_d = ac_next_c;
         end else if (busy_q) begin
            drop_d = 1'b1;
         end else begin
            start_c = 1'b1;
            if (rs_s) begin
               wr_c = sel_q & ac_loc_c.hit;
               ac_d = ac_next_c;
            end else if ((data_s2_q & OP_DDRAM) != 8'h00) begin
               ac_d  = data_s2_q[6:0];
               sel_d = 1'b1;
            end else if ((data_s2_q & OP_CGRAM) != 8'h00) begin
               sel_d = 1'b0;
            end else if ((data_s2_q & OP_FUNC) != 8'h00) begin
               // function set only costs busy time
            end else if ((data_s2_q & OP_SHIFT) != 8'h00) begin
               if (!data_s2_q[3]) ac_d = ac_next_c;
            end else if ((data_s2_q & OP_DISP) != 8'h00) begin
               // cursor/blink bits do not affect the image
               disp_d = data_s2_q[2];
            end else if ((data_s2_q & OP_ENTRY) != 8'h00) begin
               id_d = data_s2_q[1];
            end else if ((data_s2_q & OP_HOME) != 8'h00) begin
               ac_d   = 7'h00;
               long_c = 1'b1;
            end else if ((data_s2_q & OP_CLEAR) != 8'h00) begin
               ac_d   = 7'h00;
               id_d   = 1'b1;
               clr_c  = 1'b1;
               long_c = 1'b1;
            end
         end
      end
   end

   // Control registers, busy timer and registered read-back bus
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         ac_q    <= 7'h00;
         id_q    <= 1'b1;
         sel_q   <= 1'b1;
         disp_q  <= 1'b0;
         drop_q  <= 1'b0;
         busy_q  <= 1'b0;
         cnt_q   <= '0;
         dq_q    <= 8'h00;
         dq_oe_q <= 1'b0;
      end else begin
         ac_q   <= ac_d;
         id_q   <= id_d;
         sel_q  <= sel_d;
         disp_q <= disp_d;
         drop_q <= drop_d;
         if (start_c) begin
            busy_q <= 1'b1;
            cnt_q  <= long_c ? CW'(CLEAR_CYCLES - 1) : CW'(BUSY_CYCLES - 1);
         end else if (busy_q) begin
            if (cnt_q == '0) busy_q <= 1'b0;
            else             cnt_q  <= CW'(cnt_q - CW'(1));
         end
         dq_oe_q <= en_s & rw_s;
         if (en_s & rw_s) dq_q <= rs_s ? ac_char_c : {busy_q, ac_q};
         else             dq_q <= 8'h00;
      end
   end

   // DDRAM image: data writes, one-entry-per-cycle clear fill, mirror read port
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         for (int unsigned i = 0; i < DDRAM_DEPTH; i++) ddram_q[i] <= SPACE;
         fill_q     <= 1'b0;
         fill_idx_q <= 5'd0;
         rd_char_q  <= SPACE;
      end else begin
         if (clr_c) begin
            ddram_q[0] <= SPACE;
            fill_q     <= 1'b1;
            fill_idx_q <= 5'd1;
         end else if (fill_q) begin
            ddram_q[fill_idx_q] <= SPACE;
            fill_idx_q          <= 5'(fill_idx_q + 5'd1);
            if (fill_idx_q == 5'd31) fill_q <= 1'b0;
         end
         if (wr_c) ddram_q[ac_loc_c.idx] <= data_s2_q;
         rd_char_q <= ddram_q[iRD_ADDR];
      end
   end

   assign oAC        = ac_q;
   assign oDISP_ON   = disp_q;
   assign oBUSY      = busy_q;
   assign oDROP      = drop_q;
   assign oLCD_DQ    = dq_q;
   assign oLCD_DQ_OE = dq_oe_q;
   assign oRD_CHAR   = rd_char_q;

endmodule

// File: tb/tb_lcd_responder.sv
// Directed bench for lcd_responder with shortened busy timing.
module tb_lcd_responder;

   localparam int unsigned BUSY  = 20;
   localparam int unsigned CLEAR = 40;

   logic       iCLK, iRST;
   logic [7:0] LCD_DATA;
   logic       LCD_RW, LCD_EN, LCD_RS;
   logic [7:0] oLCD_DQ;
   logic       oLCD_DQ_OE;
   logic [4:0] iRD_ADDR;
   logic [7:0] oRD_CHAR;
   logic [6:0] oAC;
   logic       oDISP_ON, oBUSY, oDROP;

   int checks = 0;
   int errors = 0;

   lcd_responder #(.BUSY_CYCLES(BUSY), .CLEAR_CYCLES(CLEAR)) dut (
      .iCLK(iCLK), .iRST(iRST), .LCD_DATA(LCD_DATA), .LCD_RW(LCD_RW),
      .LCD_EN(LCD_EN), .LCD_RS(LCD_RS), .oLCD_DQ(oLCD_DQ), .oLCD_DQ_OE(oLCD_DQ_OE),
      .iRD_ADDR(iRD_ADDR), .oRD_CHAR(oRD_CHAR), .oAC(oAC), .oDISP_ON(oDISP_ON),
      .oBUSY(oBUSY), .oDROP(oDROP)
   );

   initial iCLK = 1'b0;
   always #5 iCLK = ~iCLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one bus access; EN high for 4 cycles, then wait post cycles
   task automatic access(input logic rs, input logic rw, input logic [7:0] d, input int post);
      @(negedge iCLK);
      LCD_RS = rs; LCD_RW = rw; LCD_DATA = d; LCD_EN = 1'b1;
      repeat (4) @(negedge iCLK);
      LCD_EN = 1'b0;
      repeat (post) @(negedge iCLK);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (oBUSY && n < 1000) begin
         @(negedge iCLK);
         n++;
      end
      chk("busy_timeout", 32'(n < 1000), 32'd1);
   endtask

   task automatic wr(input logic rs, input logic [7:0] d);
      access(rs, 1'b0, d, 6);
      wait_idle();
   endtask

   task automatic rd(input logic [4:0] a, output logic [7:0] c);
      iRD_ADDR = a;
      repeat (2) @(negedge iCLK);
      c = oRD_CHAR;
   endtask

   task automatic chk_all_space(input string tag);
      int bad = 0;
      logic [7:0] c;
      for (int i = 0; i < 32; i++) begin
         rd(5'(i), c);
         if (c !== 8'h20) bad++;
      end
      chk(tag, 32'(bad), 32'd0);
   endtask

   initial begin
      logic [7:0] c;
      int rise_k, bcnt, dcnt, n;
      iRST = 1'b1; LCD_DATA = 8'h00; LCD_RW = 1'b0; LCD_EN = 1'b0; LCD_RS = 1'b0;
      iRD_ADDR = 5'd0;
      repeat (3) @(negedge iCLK);
      chk("rst_ac", 32'(oAC), 32'h0);
      chk("rst_busy", 32'(oBUSY), 32'h0);
      chk("rst_disp", 32'(oDISP_ON), 32'h0);
      chk("rst_dq", 32'(oLCD_DQ), 32'h0);
      chk("rst_dq_oe", 32'(oLCD_DQ_OE), 32'h0);
      chk("rst_drop", 32'(oDROP), 32'h0);
      chk("rst_rdchar", 32'(oRD_CHAR), 32'h20);
      iRST = 1'b0;
      repeat (2) @(negedge iCLK);

      // Init sequence then first character
      wr(1'b0, 8'h38); wr(1'b0, 8'h0C); wr(1'b0, 8'h01); wr(1'b0, 8'h06); wr(1'b0, 8'h80);
      wr(1'b1, 8'h41);
      chk("init_ac", 32'(oAC), 32'h01);
      chk("init_disp", 32'(oDISP_ON), 32'h1);
      rd(5'd0, c);
      chk("init_char0", 32'(c), 32'h41);

      // Line 2 write
      wr(1'b0, 8'hC0); wr(1'b1, 8'h42);
      chk("line2_ac", 32'(oAC), 32'h41);
      rd(5'd16, c);
      chk("line2_char16", 32'(c), 32'h42);

      // Reset restores image and registers
      @(negedge iCLK); iRST = 1'b1;
      @(negedge iCLK);
      chk("rst2_ac", 32'(oAC), 32'h0);
      chk("rst2_disp", 32'(oDISP_ON), 32'h0);
      iRST = 1'b0;
      chk_all_space("rst2_ddram");

      // Invisible address 0x27: not stored, wraps to 0x40
      wr(1'b0, 8'hA7); wr(1'b1, 8'h43);
      chk("wrap27_ac", 32'(oAC), 32'h40);
      chk_all_space("wrap27_ddram");

      // Decrement from 0x00 wraps to 0x67
      wr(1'b0, 8'h04); wr(1'b0, 8'h80); wr(1'b1, 8'h44);
      chk("dec00_ac", 32'(oAC), 32'h67);
      rd(5'd0, c);
      chk("dec00_char0", 32'(c), 32'h44);

      // Data read at AC 0 returns the character and steps AC without busy
      wr(1'b0, 8'h06); wr(1'b0, 8'h80);
      @(negedge iCLK);
      LCD_RS = 1'b1; LCD_RW = 1'b1; LCD_EN = 1'b1;
      repeat (4) @(negedge iCLK);
      chk("dread_oe", 32'(oLCD_DQ_OE), 32'h1);
      chk("dread_dq", 32'(oLCD_DQ), 32'h44);
      LCD_EN = 1'b0;
      repeat (6) @(negedge iCLK);
      chk("dread_ac", 32'(oAC), 32'h01);
      chk("dread_nobusy", 32'(oBUSY), 32'h0);
      chk("dread_oe_off", 32'(oLCD_DQ_OE), 32'h0);

      // Busy-flag read right after a data write, then again once idle
      wr(1'b0, 8'h80);
      access(1'b1, 1'b0, 8'h45, 6);
      @(negedge iCLK);
      LCD_RS = 1'b0; LCD_RW = 1'b1; LCD_EN = 1'b1;
      repeat (4) @(negedge iCLK);
      chk("bf_busy_dq", 32'(oLCD_DQ), 32'h81);
      chk("bf_busy_oe", 32'(oLCD_DQ_OE), 32'h1);
      LCD_EN = 1'b0;
      repeat (6) @(negedge iCLK);
      wait_idle();
      @(negedge iCLK);
      LCD_EN = 1'b1;
      repeat (4) @(negedge iCLK);
      chk("bf_idle_dq", 32'(oLCD_DQ), 32'h01);
      chk("bf_idle_busy", 32'(oBUSY), 32'h0);
      LCD_EN = 1'b0;
      repeat (6) @(negedge iCLK);

      // Clear with a data write landing while busy
      access(1'b0, 1'b0, 8'h01, 0);
      rise_k = -1; bcnt = 0; dcnt = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge iCLK);
         if (oBUSY) bcnt++;
         if (oDROP) dcnt++;
         if (oBUSY && rise_k < 0) rise_k = k;
         if (rise_k >= 0 && k == rise_k + 2) begin
            LCD_RS = 1'b1; LCD_RW = 1'b0; LCD_DATA = 8'h55; LCD_EN = 1'b1;
         end
         if (rise_k >= 0 && k == rise_k + 5) LCD_EN = 1'b0;
      end
      chk("clr_busy_len", 32'(bcnt), 32'(CLEAR));
      chk("clr_drop_cnt", 32'(dcnt), 32'd1);
      chk("clr_ac", 32'(oAC), 32'h0);
      chk_all_space("clr_ddram");

      // Reset in the middle of a clear fill
      wr(1'b0, 8'h0C); wr(1'b0, 8'h80); wr(1'b1, 8'h46);
      rd(5'd0, c);
      chk("pre_clr_char0", 32'(c), 32'h46);
      access(1'b0, 1'b0, 8'h01, 0);
      n = 0;
      while (!oBUSY && n < 20) begin
         @(negedge iCLK);
         n++;
      end
      chk("midclr_rise", 32'(oBUSY), 32'h1);
      repeat (9) @(negedge iCLK);
      iRST = 1'b1;
      #1;
      chk("midclr_busy", 32'(oBUSY), 32'h0);
      chk("midclr_ac", 32'(oAC), 32'h0);
      chk("midclr_disp", 32'(oDISP_ON), 32'h0);
      chk("midclr_rdchar", 32'(oRD_CHAR), 32'h20);
      @(negedge iCLK);
      iRST = 1'b0;
      repeat (2) @(negedge iCLK);
      wr(1'b0, 8'h80); wr(1'b1, 8'h47);
      rd(5'd0, c);
      chk("post_rst_char0", 32'(c), 32'h47);
      chk("post_rst_ac", 32'(oAC), 32'h01);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lcd_responder.md
# lcd_responder

HD44780-compatible bus responder for the character-LCD port. It samples LCD_DATA/LCD_RS/LCD_RW/LCD_EN as driven by the LCD sequencer and controller, and decodes instructions and data writes into a 2x16 DDRAM image with address counter and busy timing. It answers busy-flag/address and data reads. Used as the on-chip display model for simulation and for mirroring LCD contents to other display paths.

## Interface
- BUSY_CYCLES, 2000: busy duration after normal instruction or data access (40 us at 50 MHz)
- CLEAR_CYCLES, 82000: busy duration after clear/return-home; must be >= 32
- iCLK  in  1  system clock
- iRST  in  1  reset, asynchronous, active-high
- LCD_DATA  in  8  bus data from controller
- LCD_RW  in  1  1 = read, 0 = write
- LCD_EN  in  1  enable strobe; access completes on falling edge
- LCD_RS  in  1  0 = instruction, 1 = data
- oLCD_DQ  out  8  read data toward controller
- oLCD_DQ_OE  out  1  oLCD_DQ valid/driven
- iRD_ADDR  in  5  mirror read index: 0-15 line 1, 16-31 line 2
- oRD_CHAR  out  8  DDRAM[iRD_ADDR], registered, 1-cycle latency
- oAC  out  7  address counter
- oDISP_ON  out  1  display-control D bit
- oBUSY  out  1  busy flag
- oDROP  out  1  1-cycle pulse: access ignored because busy

## Operation
- All four LCD inputs pass through a 2-flop synchronizer. The access strobe is the synchronized EN falling edge, sampling RS/RW/DATA from the same stage.
- Reset: DDRAM all 0x20, AC=0, I/D=1, D=0, DDRAM-select=1, oBUSY=0, oLCD_DQ=0, oLCD_DQ_OE=0, oRD_CHAR=0x20, oDROP=0.
- Write strobe while oBUSY=1: no state change; oDROP pulses.
- Instructions (RS=0, RW=0), decoded by highest set bit:
  - 0x01 clear: DDRAM filled with 0x20, AC=0, I/D=1.
  - 0x02/0x03 home: AC=0.
  - 0b000001xx entry mode: store I/D. The S (shift) bit is ignored.
  - 0b00001DCB: oDISP_ON=D. C/B are stored and unused.
  - 0b0001SRxx: with S=0, AC steps right (R=1) or left (R=0). With S=1, no effect.
  - 0b001xxxxx function set: no effect.
  - 0b01xxxxxx CGRAM address: DDRAM-select=0, so subsequent data writes are discarded; AC unchanged.
  - 0b1aaaaaaa: AC=a, DDRAM-select=1.
- Data write (RS=1, RW=0):
  - When DDRAM-select=1 and AC is visible, store at the AC's DDRAM index.
  - AC steps per I/D in all cases.
- Visibility: AC 0x00-0x0F maps to index 0-15, and 0x40-0x4F maps to index 16-31. Other valid addresses are legal but not stored; reads return 0x20.
- AC stepping:
  - Increment: 0x27->0x40, 0x67->0x00.
  - Decrement: 0x40->0x27, 0x00->0x67.
  - AC writes outside 0x00-0x27/0x40-0x67 load as-is; the next step goes to 0x00 for increment or 0x67 for decrement.
- Reads (RW=1), allowed while busy:
  - oLCD_DQ_OE=1 while synchronized EN=1 and RW=1.
  - RS=0: oLCD_DQ={oBUSY,AC}.
  - RS=1: oLCD_DQ=char at AC. AC steps per I/D on the falling edge; the step is not blocked by busy and does not set busy.

## Timing
- Strobe detection occurs 3 iCLK cycles after the raw EN falls; call the detect cycle t.
- AC/DDRAM/oDISP_ON update at t+1, and oBUSY rises at t+1.
- oBUSY stays high BUSY_CYCLES cycles, or CLEAR_CYCLES for clear/home.
- Clear fill: one DDRAM entry per cycle, t+1..t+32. AC=0 at t+1.
- Reset asserted mid-clear or mid-busy immediately restores all reset values.
- oDROP pulses at t+1.
- oLCD_DQ/oLCD_DQ_OE follow synchronized EN/RW/RS with 1 registered cycle.

## Structure
- Shared package lcd_pkg holds:
  - instruction opcode masks
  - SPACE=8'h20, LINE2_BASE=7'h40, LINE_LEN=16, LINE_END=7'h27
  - DDRAM index-mapping function
- Sub-module lcd_ac_step (7-bit AC, dir -> next AC with wrap rules). It is combinational and shared by the instruction, data-write and read paths.
- Busy counter width: $clog2(CLEAR_CYCLES+1).

## Test plan
- Init sequence 0x038, 0x00C, 0x001, 0x006, 0x080, then data 0x41, each after busy clears -> DDRAM[0]=0x41, oAC=0x01, oDISP_ON=1, oRD_CHAR(iRD_ADDR=0)=0x41.
- Instruction 0x0C0, data 0x42 -> DDRAM[16]=0x42, oAC=0x41. Reset -> all DDRAM 0x20, oAC=0.
- AC=0x27 with I/D=1, data 0x43 -> not stored, oAC=0x40. Entry 0x004, AC=0x00, data -> oAC=0x67.
- Data write, then immediate RS=0 read -> oLCD_DQ=0x80|AC. After BUSY_CYCLES -> bit7=0 and oBUSY=0.
- Instruction 0x001 followed by data write 2 cycles after busy rises -> oDROP pulse, DDRAM all 0x20. oBUSY high exactly CLEAR_CYCLES.
- iRST asserted at fill cycle 10 of a clear -> outputs at reset values the same cycle. After release, a normal write succeeds.
